// File: rtl/pattern_pkg.sv
// Shared types and constants for the serial link into the pattern detector.
package pattern_pkg;
   localparam int DEF_WORD_W = 10;
   localparam int GAP_W      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } ser_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping upward.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   input  logic               i_en,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   always_comb begin
      int   j;
      logic found;
      j       = 0;
      found   = 1'b0;
      o_grant = '0;
      o_idx   = '0;
      o_any   = |i_req;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(i_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && i_req[IDX_W'(j)]) begin
            found = 1'b1;
            o_idx = IDX_W'(j);
            // Grant stays silent outside arbitration points so req_ready never leaks.
            if (i_en) o_grant[IDX_W'(j)] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/serial_frame_arbiter.sv
// Round-robin arbitration of NUM_REQ word sources onto one LSB-first serial link,
// with frame markers and a programmable inter-frame gap.
module serial_frame_arbiter
   import pattern_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int WORD_W     = DEF_WORD_W,
   parameter  int GAP_CYCLES = 0,
   localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*WORD_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      ser_stall,
   output logic                      ser_data,
   output logic                      ser_valid,
   output logic                      ser_first,
   output logic                      ser_last,
   output logic [IDX_W-1:0]          ser_src,
   output logic                      busy,
   output ser_state_e                dbg_state
);

   localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   ser_state_e          r_state;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [IDX_W-1:0]    r_src;
   logic [WORD_W-1:0]   r_shreg;
   logic [BIT_W-1:0]    r_bit_idx;
   logic [GAP_W-1:0]    r_gap_cnt;

   logic                w_last_bit;
   logic                w_arb_pt;
   logic                w_arb_en;
   logic                w_any;
   logic                w_take;
   logic [NUM_REQ-1:0]  w_grant;
   logic [IDX_W-1:0]    w_idx;
   logic [IDX_W-1:0]    w_next_ptr;
   logic [WORD_W-1:0]   w_words [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
      assign w_words[gi] = req_data[gi*WORD_W +: WORD_W];
   end

   assign w_last_bit = (r_bit_idx == BIT_W'(WORD_W - 1));

   always_comb begin
      w_arb_pt = 1'b0;
      case (r_state)
         IDLE:    w_arb_pt = 1'b1;
         SHIFT:   w_arb_pt = !ser_stall && w_last_bit && (GAP_CYCLES == 0);
         GAP:     w_arb_pt = (r_gap_cnt == '0);
         default: w_arb_pt = 1'b0;
      endcase
   end

   assign w_arb_en   = w_arb_pt && !reset;
   assign w_take     = w_arb_pt && w_any;
   assign w_next_ptr = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .i_en    (w_arb_en),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // Handshake: a word is transferred in the cycle where req_valid[i] and req_ready[i]
   // are both high; req_ready is a one-cycle pulse and the source must hold its word until then.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_rr_ptr  <= '0;
         r_src     <= '0;
         r_shreg   <= '0;
         r_bit_idx <= '0;
         r_gap_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: ;
            SHIFT: begin
               if (!ser_stall) begin
                  r_shreg   <= r_shreg >> 1;
                  r_bit_idx <= r_bit_idx + BIT_W'(1);
                  if (w_last_bit) begin
                     if (GAP_CYCLES > 0) begin
                        r_state   <= GAP;
                        r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                     end else begin
                        r_state <= IDLE;
                     end
                  end
               end
            end
            GAP: begin
               if (r_gap_cnt == '0) r_state   <= IDLE;
               else                 r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
            default: r_state <= IDLE;
         endcase
         // A grant overrides whatever the state decode above chose.
         if (w_take) begin
            r_shreg   <= w_words[w_idx];
            r_src     <= w_idx;
            r_bit_idx <= '0;
            r_rr_ptr  <= w_next_ptr;
            r_state   <= SHIFT;
         end
      end
   end

   assign req_ready = w_grant;
   assign ser_data  = r_shreg[0];
   assign ser_valid = (r_state == SHIFT) && !ser_stall;
   assign ser_first = ser_valid && (r_bit_idx == '0);
   assign ser_last  = ser_valid && w_last_bit;
   assign ser_src   = r_src;
   assign busy      = (r_state != IDLE);
   assign dbg_state = r_state;

endmodule

// File: doc/serial_frame_arbiter.md
# serial_frame_arbiter

Shares the single serial link into the pattern detector among NUM_REQ parallel word sources. A round-robin arbiter picks one requester per frame; a serializer shifts its WORD_W-bit word out LSB-first, one bit per clock. Frame-marker outputs tell the detector where each frame starts and ends, and a programmable inter-frame gap is inserted between frames. The block sits between the incremental data generators and the serial pattern detector.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WORD_W, 10, bits per frame (≥2)
- GAP_CYCLES, 0, idle cycles between the last bit of one frame and the first bit of the next (0..15)
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  NUM_REQ  requester i has a word pending
- req_data  in  NUM_REQ*WORD_W  word of requester i at bits [i*WORD_W +: WORD_W]
- req_ready  out  NUM_REQ  one-hot handshake pulse: the word of requester i is captured this cycle
- ser_stall  in  1  downstream hold; freezes shifting
- ser_data  out  1  serial bit (LSB of word first)
- ser_valid  out  1  ser_data carries a frame bit this cycle
- ser_first  out  1  bit 0 of a frame
- ser_last  out  1  bit WORD_W-1 of a frame
- ser_src  out  $clog2(NUM_REQ)  index of the requester owning the current frame
- busy  out  1  state != IDLE

## Operation
- States: IDLE, SHIFT, GAP.
- Arbitration points:
  - every IDLE cycle;
  - the last unstalled SHIFT cycle (bit WORD_W-1), only when GAP_CYCLES==0;
  - the final GAP cycle.
- At an arbitration point with any req_valid set:
  - the grant g is the first valid requester at or after rr_ptr, searching upward and wrapping;
  - req_ready[g]=1 for that cycle only;
  - at the edge: shreg<=req_data[g], ser_src<=g, bit_idx<=0, rr_ptr<=(g+1) mod NUM_REQ, state<=SHIFT.
- Arbitration point with no request:
  - from IDLE: stay in IDLE;
  - from SHIFT or GAP: go to IDLE.
- SHIFT:
  - unstalled cycle: shreg>>=1, bit_idx++;
  - at bit_idx==WORD_W-1 with GAP_CYCLES>0: go to GAP with gap_cnt=GAP_CYCLES-1;
  - stalled cycle: shreg, bit_idx and state hold; no arbitration.
- GAP: gap_cnt decrements each cycle; the cycle with gap_cnt==0 is the arbitration point. ser_stall is ignored outside SHIFT.
- Output decode:
  - ser_data=shreg[0];
  - ser_valid=(state==SHIFT)&&!ser_stall;
  - ser_first=ser_valid&&bit_idx==0;
  - ser_last=ser_valid&&bit_idx==WORD_W-1.
- Requesters hold req_valid and req_data stable until req_ready. The block does not check this.
- req_ready is never asserted during reset, in a SHIFT cycle other than an arbitration point, or in a non-final GAP cycle.

## Timing
- Reset values: state=IDLE, rr_ptr=0, shreg=0, bit_idx=0, gap_cnt=0. All outputs are 0: req_ready, ser_data, ser_valid, ser_first, ser_last, ser_src, busy.
- Latency: the req_ready cycle is N; the first bit (ser_first) appears at N+1; the last bit at N+WORD_W (plus stall cycles).
- Frame spacing:
  - GAP_CYCLES==0 with a request pending: the next ser_first immediately follows ser_last (zero bubble);
  - GAP_CYCLES==G>0: exactly G cycles with ser_valid=0 between them.
- Reset asserted mid-frame: the frame is dropped and all outputs drop asynchronously. After release, the first grant searches from requester 0.
- ser_stall asserted on the last bit: ser_last stays low until the stall is released. The arbitration point and req_ready move to the release cycle.

## Structure
- Shared package pattern_pkg:
  - WORD_W default 10;
  - typedef enum ser_state_e {IDLE, SHIFT, GAP};
  - GAP_W=4.
- Sub-module rr_arbiter (NUM_REQ):
  - inputs: req vector, rr_ptr, an enable;
  - outputs: one-hot grant, grant index, any_req;
  - combinational pick only; rr_ptr is registered in the parent.

## Test plan
- Single requester 0, data 10'h2C9, GAP=0, no stall: req_ready[0] in one cycle. On the next 10 cycles ser_data=1,0,0,1,0,0,1,1,0,1, with ser_first on the 1st cycle and ser_last on the 10th. ser_src=0.
- All 4 requesters valid continuously after reset: grant order 0,1,2,3,0. Frames are back-to-back with no ser_valid gap.
- Only requesters 1 and 3 valid: grants alternate 1,3,1. rr_ptr wraps correctly from 3 to 0.
- GAP_CYCLES=2 with requesters 0 and 2 always valid: exactly 2 ser_valid=0 cycles between ser_last and the next ser_first. req_ready occurs in the second gap cycle.
- ser_stall high for 3 cycles at bit 4 and for 1 cycle at bit 9: the frame completes with all 10 bits intact. ser_valid is low during the stall cycles, and req_ready is delayed to the last-bit release cycle.
- reset pulsed at bit 5 of a requester-2 frame, with requesters 1 and 2 valid after release: all outputs are 0 immediately. The first new grant goes to requester 1, and the frame restarts at bit 0.
